// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver
// Time-multiplexed seven-segment driver for DIGITS hex digits.
// A packed word is captured into a holding register on load_i. The word is
// copied into the display register only when the scan wraps from the last
// digit back to digit 0, so a frame never shows a mix of old and new data.
// Each digit stays enabled for REFRESH_DIV clocks.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   bin_i         packed digit values, digit i = bin_i[4i+3:4i], digit 0 rightmost
//   dp_i          decimal point request per digit
//   load_i        capture bin_i/dp_i into the holding register
//   blank_lz_i    leading-zero blanking enable (used live, not buffered)
//   out_o         segments, out_o[0]=a .. out_o[6]=g
//   dp_out_o      decimal point segment
//   an_o          one-hot digit enable
//   frame_done_o  one-cycle pulse in the first cycle of each frame
module seg7_mux_driver #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*DIGITS-1:0]   bin_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic                  load_i,
    input  logic                  blank_lz_i,
    output logic [6:0]            out_o,
    output logic                  dp_out_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_done_o
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0]     PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);

    // Pin-level values of the logical "off" state.
    localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic              DP_OFF  = ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW}};

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] holdBin_q, holdBin_d;
    logic [DIGITS-1:0]   holdDp_q, holdDp_d;
    logic [4*DIGITS-1:0] dispBin_q, dispBin_d;
    logic [DIGITS-1:0]   dispDp_q, dispDp_d;
    logic [6:0]          seg_q, seg_d;
    logic                dpOut_q, dpOut_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frameDone_q, frameDone_d;

    logic                tick;
    logic                wrap;
    logic [3:0]          curNib;
    logic                curDp;
    logic                upperZero;
    logic                blankDigit;
    logic [DIGITS-1:0]   anLogic;

    // Hex to segments, gfedcba order, 1 = lit.
    function automatic logic [6:0] hexToSeg(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h00;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Next-state logic: prescaler/index scan, holding and display buffers,
    // and the pin values for the digit currently indexed. The display copy
    // uses the pre-load holding value, so a load landing on the wrap edge
    // shows up one frame later.
    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        wrap      = tick && (idx_q == IDX_LAST);

        presc_d   = tick ? '0 : presc_q + PW'(1);
        idx_d     = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IW'(1);
        end

        holdBin_d = load_i ? bin_i : holdBin_q;
        holdDp_d  = load_i ? dp_i  : holdDp_q;
        dispBin_d = wrap ? holdBin_q : dispBin_q;
        dispDp_d  = wrap ? holdDp_q  : dispDp_q;

        curNib    = 4'h0;
        curDp     = 1'b0;
        anLogic   = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            anLogic[i] = (idx_q == IW'(i));
            if (idx_q == IW'(i)) begin
                curNib = dispBin_q[4*i +: 4];
                curDp  = dispDp_q[i];
            end
        end

        // Walking down from the top digit, a digit is blankable while every
        // digit from the top down to it is zero. Digit 0 is never visited.
        upperZero  = 1'b1;
        blankDigit = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            upperZero = upperZero && (dispBin_q[4*i +: 4] == 4'h0);
            if ((idx_q == IW'(i)) && upperZero) begin
                blankDigit = 1'b1;
            end
        end

        seg_d       = (blank_lz_i && blankDigit) ? 7'h00 : hexToSeg(curNib);
        seg_d       = seg_d ^ {7{ACTIVE_LOW}};
        dpOut_d     = curDp ^ ACTIVE_LOW;
        an_d        = anLogic ^ {DIGITS{ACTIVE_LOW}};
        frameDone_d = (idx_q == '0) && (presc_q == '0);
    end

    // State and pin registers. Reset wins over a simultaneous load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q     <= '0;
            idx_q       <= '0;
            holdBin_q   <= '0;
            holdDp_q    <= '0;
            dispBin_q   <= '0;
            dispDp_q    <= '0;
            seg_q       <= SEG_OFF;
            dpOut_q     <= DP_OFF;
            an_q        <= AN_OFF;
            frameDone_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            holdBin_q   <= holdBin_d;
            holdDp_q    <= holdDp_d;
            dispBin_q   <= dispBin_d;
            dispDp_q    <= dispDp_d;
            seg_q       <= seg_d;
            dpOut_q     <= dpOut_d;
            an_q        <= an_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign out_o        = seg_q;
    assign dp_out_o     = dpOut_q;
    assign an_o         = an_q;
    assign frame_done_o = frameDone_q;

endmodule
